// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states, IF/ID register layout
// and the bubble constants used by the front end of the pipeline.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_INC   = 32'd4;
  localparam word_t NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, npc: 32'd0, valid: 1'b0};

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch-stage signals as seen from the fetch stage itself.
interface fetch_if (
  input logic CLK,
  input logic nRST
);
  import cpu_types_pkg::*;

  word_t imemaddr;
  logic  pcEN;
  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  flush;
  logic  halt;
  word_t instr_out;
  word_t npc_out;
  logic  valid_out;

  modport fetch (
    input  CLK, nRST, imemaddr, ihit, imemload, stall, flush, halt,
    output pcEN, iREN, iaddr, instr_out, npc_out, valid_out
  );

endinterface

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: bubble beats load, otherwise the contents hold.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // NOTE: sequential state is written with <= only, so every register in the
  // design samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       q <= IFID_BUBBLE;
    else if (bubble) q <= IFID_BUBBLE;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: requests imemaddr from the icache, fills IF/ID, and
// parks a returned instruction in a one-entry skid buffer while decode stalls.
module fetch_stage
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  word_t imemaddr,
  output logic  pcEN,
  output logic  iREN,
  output word_t iaddr,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  flush,
  input  logic  halt,
  output word_t instr_out,
  output word_t npc_out,
  output logic  valid_out
);

  fetch_state_t state, state_next;
  word_t        skid_instr, skid_npc;
  logic         skid_ld, skid_clr;
  logic         ifid_ld, ifid_bubble;
  ifid_t        ifid_d, ifid_q;
  word_t        npc;

  assign npc   = imemaddr + PC_INC;
  assign iaddr = imemaddr;
  assign iREN  = (state == REQ);
  assign pcEN  = nRST & (flush | ((state == REQ) & ihit));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= REQ;
    else       state <= state_next;
  end

  // Skid contents are meaningful only in HOLD; clearing keeps stale words out of view.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skid_instr <= NOP_WORD;
      skid_npc   <= '0;
    end else if (skid_clr) begin
      skid_instr <= NOP_WORD;
      skid_npc   <= '0;
    end else if (skid_ld) begin
      skid_instr <= imemload;
      skid_npc   <= npc;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches below can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    ifid_ld     = 1'b0;
    ifid_bubble = 1'b0;
    ifid_d      = '{instr: imemload, npc: npc, valid: 1'b1};
    skid_ld     = 1'b0;
    skid_clr    = 1'b0;

    if (flush) begin
      ifid_bubble = 1'b1;
      skid_clr    = 1'b1;
      state_next  = REQ;
    end else if (halt) begin
      ifid_bubble = !stall;
      skid_clr    = 1'b1;
      state_next  = HALTED;
    end else begin
      unique case (state)
        REQ: begin
          if (ihit && !stall) begin
            ifid_ld = 1'b1;
          end else if (ihit) begin
            skid_ld    = 1'b1;
            state_next = HOLD;
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_ld    = 1'b1;
            ifid_d     = '{instr: skid_instr, npc: skid_npc, valid: 1'b1};
            skid_clr   = 1'b1;
            state_next = REQ;
          end
        end
        HALTED: begin
          // Nothing new enters decode until a flush restarts fetching.
          ifid_bubble = !stall;
        end
        default: state_next = REQ;
      endcase
    end
  end

  ifid_latch u_ifid (
    .CLK    (CLK),
    .nRST   (nRST),
    .load   (ifid_ld),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign instr_out = ifid_q.instr;
  assign npc_out   = ifid_q.npc;
  assign valid_out = ifid_q.valid;

endmodule
